// File: rtl/shift_issue_arb_if.sv
// Handshake and datapath bundle for shift_issue_arb.
//   Req0/Req1 : request valid, opcode, condition LUT, operands in; one-cycle ack out
//   SU        : enable, opcode, cond, operands to the shift unit; result/valid/cond back
//   Output    : buffered valid, data, cond bit, requester ID; Nack in; sticky error out
// modport slave is the arbiter's view, modport master is the surrounding logic's view.
interface shift_issue_arb_if #(
    parameter int unsigned WIDTH_DATA = 32,
    parameter int unsigned WIDTH_OPC  = 4,
    parameter int unsigned WIDTH_LUT  = 8
);
    logic                  I_Req0_Valid;
    logic [WIDTH_OPC-1:0]  I_Req0_Opcode;
    logic [WIDTH_LUT-1:0]  I_Req0_Cond;
    logic [WIDTH_DATA-1:0] I_Req0_A;
    logic [WIDTH_DATA-1:0] I_Req0_B;
    logic                  O_Req0_Ack;

    logic                  I_Req1_Valid;
    logic [WIDTH_OPC-1:0]  I_Req1_Opcode;
    logic [WIDTH_LUT-1:0]  I_Req1_Cond;
    logic [WIDTH_DATA-1:0] I_Req1_A;
    logic [WIDTH_DATA-1:0] I_Req1_B;
    logic                  O_Req1_Ack;

    logic                  O_SU_En;
    logic [WIDTH_OPC-1:0]  O_SU_Opcode;
    logic [WIDTH_LUT-1:0]  O_SU_Cond;
    logic [WIDTH_DATA-1:0] O_SU_A;
    logic [WIDTH_DATA-1:0] O_SU_B;
    logic                  I_SU_Valid;
    logic [WIDTH_DATA-1:0] I_SU_Data;
    logic                  I_SU_CondOut;

    logic                  O_Valid;
    logic [WIDTH_DATA-1:0] O_Data;
    logic                  O_CondOut;
    logic                  O_Id;
    logic                  I_Nack;
    logic                  O_Err;

    modport slave (
        input  I_Req0_Valid, I_Req0_Opcode, I_Req0_Cond, I_Req0_A, I_Req0_B,
        output O_Req0_Ack,
        input  I_Req1_Valid, I_Req1_Opcode, I_Req1_Cond, I_Req1_A, I_Req1_B,
        output O_Req1_Ack,
        output O_SU_En, O_SU_Opcode, O_SU_Cond, O_SU_A, O_SU_B,
        input  I_SU_Valid, I_SU_Data, I_SU_CondOut,
        output O_Valid, O_Data, O_CondOut, O_Id, O_Err,
        input  I_Nack
    );

    modport master (
        output I_Req0_Valid, I_Req0_Opcode, I_Req0_Cond, I_Req0_A, I_Req0_B,
        input  O_Req0_Ack,
        output I_Req1_Valid, I_Req1_Opcode, I_Req1_Cond, I_Req1_A, I_Req1_B,
        input  O_Req1_Ack,
        input  O_SU_En, O_SU_Opcode, O_SU_Cond, O_SU_A, O_SU_B,
        output I_SU_Valid, I_SU_Data, I_SU_CondOut,
        input  O_Valid, O_Data, O_CondOut, O_Id, O_Err,
        output I_Nack
    );
endinterface

// File: rtl/shift_issue_arb.sv
// Round-robin issue arbiter sharing one shift unit between two requesters, with a
// one-entry result buffer and nack-based backpressure.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus          : shift_issue_arb_if.slave (requests/acks, shift-unit drive and result,
//                  output buffer, nack, sticky error)
// Optional build macro SHIFT_ISSUE_ARB_STATS_EN adds saturating 16-bit counters:
//   O_GrantCnt0/O_GrantCnt1 (grants per requester), O_StallCnt (cycles in stall).
module shift_issue_arb #(
    parameter int unsigned WIDTH_DATA = 32,
    parameter int unsigned WIDTH_OPC  = 4,
    parameter int unsigned WIDTH_LUT  = 8
) (
    input  logic         clock,
    input  logic         reset,
    shift_issue_arb_if.slave bus
`ifdef SHIFT_ISSUE_ARB_STATS_EN
    ,
    output logic [15:0]  O_GrantCnt0,
    output logic [15:0]  O_GrantCnt1,
    output logic [15:0]  O_StallCnt
`endif
);

    typedef enum logic [1:0] {StIdle, StFull, StStall} state_e;

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;     // 0: Req0 has priority, 1: Req1
    logic [WIDTH_DATA-1:0] data_q, data_d;
    logic                  cond_q, cond_d;
    logic                  id_q, id_d;
    logic                  err_q, err_d;

    logic buf_valid, drain, can_issue, gnt0, gnt1, issue, load;

    always_comb begin
        buf_valid = (state_q != StIdle);
        drain     = buf_valid & ~bus.I_Nack;
        // Acks are combinational, so they must be masked while reset is asserted.
        can_issue = ~reset & (~buf_valid | drain);
        gnt0      = can_issue & bus.I_Req0_Valid & (~bus.I_Req1_Valid | ~ptr_q);
        gnt1      = can_issue & bus.I_Req1_Valid & (~bus.I_Req0_Valid |  ptr_q);
        issue     = gnt0 | gnt1;
        // An issue the shift unit does not validate is acked but leaves no result.
        load      = issue & bus.I_SU_Valid;
    end

    always_comb begin
        bus.O_Req0_Ack  = gnt0;
        bus.O_Req1_Ack  = gnt1;
        bus.O_SU_En     = issue;
        bus.O_SU_Opcode = '0;
        bus.O_SU_Cond   = '0;
        bus.O_SU_A      = '0;
        bus.O_SU_B      = '0;
        if (gnt0) begin
            bus.O_SU_Opcode = bus.I_Req0_Opcode;
            bus.O_SU_Cond   = bus.I_Req0_Cond;
            bus.O_SU_A      = bus.I_Req0_A;
            bus.O_SU_B      = bus.I_Req0_B;
        end else if (gnt1) begin
            bus.O_SU_Opcode = bus.I_Req1_Opcode;
            bus.O_SU_Cond   = bus.I_Req1_Cond;
            bus.O_SU_A      = bus.I_Req1_A;
            bus.O_SU_B      = bus.I_Req1_B;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        cond_d  = cond_q;
        id_d    = id_q;
        err_d   = err_q | (issue & ~bus.I_SU_Valid);

        // Pointer always moves past whoever won.
        if (gnt0) begin
            ptr_d = 1'b1;
        end else if (gnt1) begin
            ptr_d = 1'b0;
        end

        if (load) begin
            data_d = bus.I_SU_Data;
            cond_d = bus.I_SU_CondOut;
            id_d   = gnt1;
        end

        unique case (state_q)
            StIdle: begin
                if (load) state_d = StFull;
            end
            StFull, StStall: begin
                if (load) begin
                    state_d = StFull;
                end else if (drain) begin
                    state_d = StIdle;
                end else begin
                    state_d = StStall;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            data_q  <= '0;
            cond_q  <= 1'b0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            cond_q  <= cond_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign bus.O_Valid   = buf_valid;
    assign bus.O_Data    = data_q;
    assign bus.O_CondOut = cond_q;
    assign bus.O_Id      = id_q;
    assign bus.O_Err     = err_q;

`ifdef SHIFT_ISSUE_ARB_STATS_EN
    logic [15:0] gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d, scnt_q, scnt_d;

    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        scnt_d  = scnt_q;
        if (gnt0 && gcnt0_q != 16'hFFFF) gcnt0_d = gcnt0_q + 16'd1;
        if (gnt1 && gcnt1_q != 16'hFFFF) gcnt1_d = gcnt1_q + 16'd1;
        if (state_q == StStall && scnt_q != 16'hFFFF) scnt_d = scnt_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
            scnt_q  <= '0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
            scnt_q  <= scnt_d;
        end
    end

    assign O_GrantCnt0 = gcnt0_q;
    assign O_GrantCnt1 = gcnt1_q;
    assign O_StallCnt  = scnt_q;
`endif

endmodule

// File: tb/tb_shift_issue_arb.sv
module tb_shift_issue_arb;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    shift_issue_arb_if #(.WIDTH_DATA(32), .WIDTH_OPC(4), .WIDTH_LUT(8)) bus ();

`ifdef SHIFT_ISSUE_ARB_STATS_EN
    logic [15:0] gcnt0, gcnt1, scnt;
`endif

    shift_issue_arb #(.WIDTH_DATA(32), .WIDTH_OPC(4), .WIDTH_LUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef SHIFT_ISSUE_ARB_STATS_EN
        ,
        .O_GrantCnt0 (gcnt0),
        .O_GrantCnt1 (gcnt1),
        .O_StallCnt  (scnt)
`endif
    );

    typedef struct {
        logic [3:0]  opc;
        logic [7:0]  cond;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        cond;
    } res_t;

    req_t req0_q[$];
    req_t req1_q[$];
    res_t exp_q[$];
    int   gnt_exp[$];
    int   ack_cyc[$];
    int   drain_cyc[$];

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;
    int n_acks   = 0;
    bit ack0_seen = 1'b0;
    bit ack1_seen = 1'b0;
    bit su_ok     = 1'b1;

    // Behavioural shift unit: [1:0] 00 srl, 01 sra, 10 sll, 11 rotl; cond = LUT[result[2:0]].
    function automatic logic [31:0] su_fn(logic [3:0] opc, logic [31:0] a, logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (opc[1:0])
            2'b00:   return a >> s;
            2'b01:   return $unsigned($signed(a) >>> s);
            2'b10:   return a << s;
            default: return (a << s) | (a >> (6'd32 - {1'b0, s}));
        endcase
    endfunction

    logic [31:0] su_res;
    always_comb su_res = su_fn(bus.O_SU_Opcode, bus.O_SU_A, bus.O_SU_B);
    assign bus.I_SU_Data    = su_res;
    assign bus.I_SU_CondOut = bus.O_SU_Cond[su_res[2:0]];
    assign bus.I_SU_Valid   = bus.O_SU_En & su_ok;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic rq(bit id, logic [3:0] opc, logic [7:0] cond, logic [31:0] a, logic [31:0] b);
        req_t r;
        r.opc = opc; r.cond = cond; r.a = a; r.b = b;
        if (id) req1_q.push_back(r);
        else req0_q.push_back(r);
    endtask

    task automatic ex(bit id, logic [31:0] data, logic cond);
        res_t e;
        e.id = id; e.data = data; e.cond = cond;
        exp_q.push_back(e);
        gnt_exp.push_back(int'(id));
    endtask

    task automatic wait_acks(int target, int budget);
        int n = 0;
        while (n_acks < target) begin
            @(negedge clock);
            n++;
            if (n > budget) begin
                fail_now("timeout_waiting_for_ack");
                break;
            end
        end
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while (req0_q.size() != 0 || req1_q.size() != 0 || exp_q.size() != 0 ||
               gnt_exp.size() != 0) begin
            @(negedge clock);
            n++;
            if (n > budget) begin
                fail_now("timeout_waiting_for_idle");
                break;
            end
        end
        @(posedge clock);
        #2;
    endtask

    // Requester driver: retires the presented request after it was acked.
    initial begin
        bus.I_Req0_Valid = 0; bus.I_Req0_Opcode = 0; bus.I_Req0_Cond = 0;
        bus.I_Req0_A = 0; bus.I_Req0_B = 0;
        bus.I_Req1_Valid = 0; bus.I_Req1_Opcode = 0; bus.I_Req1_Cond = 0;
        bus.I_Req1_A = 0; bus.I_Req1_B = 0;
        forever begin
            @(posedge clock);
            #1;
            if (ack0_seen && req0_q.size() > 0) req0_q.delete(0);
            if (ack1_seen && req1_q.size() > 0) req1_q.delete(0);
            bus.I_Req0_Valid = (req0_q.size() > 0);
            bus.I_Req1_Valid = (req1_q.size() > 0);
            if (req0_q.size() > 0) begin
                bus.I_Req0_Opcode = req0_q[0].opc; bus.I_Req0_Cond = req0_q[0].cond;
                bus.I_Req0_A = req0_q[0].a; bus.I_Req0_B = req0_q[0].b;
            end
            if (req1_q.size() > 0) begin
                bus.I_Req1_Opcode = req1_q[0].opc; bus.I_Req1_Cond = req1_q[0].cond;
                bus.I_Req1_A = req1_q[0].a; bus.I_Req1_B = req1_q[0].b;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            ack0_seen = bus.O_Req0_Ack;
            ack1_seen = bus.O_Req1_Ack;
            if (reset) begin
                chk("ack_during_reset", {bus.O_Req0_Ack, bus.O_Req1_Ack}, 0);
            end else begin
                if (bus.O_Req0_Ack || bus.O_Req1_Ack) begin
                    n_acks++;
                    ack_cyc.push_back(cyc);
                    chk("single_grant", bus.O_Req0_Ack & bus.O_Req1_Ack, 0);
                    chk("su_en_on_issue", bus.O_SU_En, 1);
                    if (gnt_exp.size() == 0) begin
                        fail_now("unexpected_ack");
                    end else begin
                        chk("grant_id", bus.O_Req1_Ack, gnt_exp.pop_front());
                        if (bus.O_Req1_Ack && req1_q.size() > 0)
                            chk("su_a_from_req1", bus.O_SU_A, req1_q[0].a);
                        else if (!bus.O_Req1_Ack && req0_q.size() > 0)
                            chk("su_a_from_req0", bus.O_SU_A, req0_q[0].a);
                    end
                end else begin
                    chk("su_en_idle", bus.O_SU_En, 0);
                    chk("su_bus_idle", |{bus.O_SU_Opcode, bus.O_SU_Cond, bus.O_SU_A, bus.O_SU_B},
                        0);
                end
                if (bus.O_Valid) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_result");
                    end else if (!bus.I_Nack) begin
                        res_t e;
                        e = exp_q.pop_front();
                        drain_cyc.push_back(cyc);
                        chk("result_data", bus.O_Data, e.data);
                        chk("result_id", bus.O_Id, e.id);
                        chk("result_cond", bus.O_CondOut, e.cond);
                    end else begin
                        chk("stall_data_hold", bus.O_Data, exp_q[0].data);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        fail_now("global_timeout");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        bus.I_Nack = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_valid", bus.O_Valid, 0);
        chk("reset_err", bus.O_Err, 0);
        chk("reset_data", bus.O_Data, 0);
        @(posedge clock);
        #2;
        reset = 1'b0;

        // Single Req0 issue, one-cycle latency.
        ack_cyc.delete(); drain_cyc.delete();
        rq(0, 4'b0010, 8'h01, 32'h0000_00F0, 32'd4);
        ex(0, 32'h0000_0F00, 1'b1);
        wait_idle(50);
        if (ack_cyc.size() == 1 && drain_cyc.size() == 1)
            chk("t1_latency", drain_cyc[0] - ack_cyc[0], 1);
        else fail_now("t1_missing_events");

        // Lone Req1 wins although pointer favours it anyway; leaves pointer at Req0.
        rq(1, 4'b0000, 8'h01, 32'h0000_1234, 32'd4);
        ex(1, 32'h0000_0123, 1'b0);
        wait_idle(50);

        // Both valid, four back-to-back issues alternating 0,1,0,1.
        ack_cyc.delete(); drain_cyc.delete();
        rq(0, 4'b0010, 8'hFE, 32'h0000_0001, 32'd3);
        rq(1, 4'b0000, 8'h02, 32'h8000_0000, 32'd31);
        rq(0, 4'b0010, 8'h40, 32'h0000_0003, 32'd1);
        rq(1, 4'b0000, 8'h08, 32'hFFFF_FFFF, 32'd29);
        ex(0, 32'h0000_0008, 1'b0);
        ex(1, 32'h0000_0001, 1'b1);
        ex(0, 32'h0000_0006, 1'b1);
        ex(1, 32'h0000_0007, 1'b0);
        wait_idle(50);
        if (ack_cyc.size() == 4 && drain_cyc.size() == 4) begin
            chk("t2_acks_back_to_back", ack_cyc[3] - ack_cyc[0], 3);
            chk("t2_no_bubble", drain_cyc[3] - drain_cyc[0], 3);
        end else fail_now("t2_missing_events");

        // Backpressure: nack held 3 cycles with buffer full and Req1 waiting.
        ack_cyc.delete(); drain_cyc.delete();
        bus.I_Nack = 1'b1;
        rq(0, 4'b0010, 8'h10, 32'h0000_0001, 32'd2);
        rq(1, 4'b0000, 8'h00, 32'h0000_0100, 32'd8);
        ex(0, 32'h0000_0004, 1'b1);
        ex(1, 32'h0000_0001, 1'b0);
        base = n_acks;
        wait_acks(base + 1, 50);
        repeat (4) @(posedge clock);
        #2;
        bus.I_Nack = 1'b0;
        wait_idle(50);
        if (ack_cyc.size() == 2 && drain_cyc.size() == 2) begin
            chk("t3_no_issue_in_stall", ack_cyc[1] - ack_cyc[0], 4);
            chk("t3_drain_with_issue", drain_cyc[0], ack_cyc[1]);
            chk("t3_new_result_next", drain_cyc[1] - ack_cyc[1], 1);
        end else fail_now("t3_missing_events");
        chk("err_clean_before_fault", bus.O_Err, 0);

        // Issue the shift unit does not validate: acked, sticky error, nothing buffered.
        su_ok = 1'b0;
        rq(1, 4'b0010, 8'hFF, 32'h0000_0005, 32'd1);
        gnt_exp.push_back(1);
        base = n_acks;
        wait_acks(base + 1, 50);
        @(posedge clock);
        #2;
        su_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("t4_err_sticky", bus.O_Err, 1);
            chk("t4_no_result", bus.O_Valid, 0);
        end
        wait_idle(50);

        // Reset with buffer full and both requesters valid; pointer would favour Req1.
        bus.I_Nack = 1'b1;
        rq(0, 4'b0010, 8'h00, 32'h0000_000A, 32'd1);
        rq(0, 4'b0010, 8'h01, 32'h0000_0001, 32'd5);
        rq(1, 4'b0000, 8'h04, 32'h0000_0040, 32'd5);
        ex(0, 32'h0000_0014, 1'b0);
        base = n_acks;
        wait_acks(base + 1, 50);
        @(posedge clock);
        #2;
        reset = 1'b1;
        exp_q.delete();
        gnt_exp.delete();
        ex(0, 32'h0000_0020, 1'b1);
        ex(1, 32'h0000_0002, 1'b1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        bus.I_Nack = 1'b0;
        @(negedge clock);
        chk("t5_valid_cleared", bus.O_Valid, 0);
        chk("t5_err_cleared", bus.O_Err, 0);
        wait_idle(50);

        // Counter scenario: fresh reset, 5 grants to Req0, 3 to Req1, 2 stall cycles.
        reset = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
`ifdef SHIFT_ISSUE_ARB_STATS_EN
        @(negedge clock);
        chk("stats_grant0_reset", gcnt0, 0);
        chk("stats_stall_reset", scnt, 0);
        @(posedge clock);
        #2;
`endif
        bus.I_Nack = 1'b1;
        for (int k = 0; k < 5; k++) rq(0, 4'b0010, 8'h00, 32'(k + 1), 32'd0);
        for (int k = 0; k < 3; k++) rq(1, 4'b0000, 8'hFF, 32'((k + 1) << 4), 32'd4);
        for (int k = 0; k < 3; k++) begin
            ex(0, 32'(k + 1), 1'b0);
            ex(1, 32'(k + 1), 1'b1);
        end
        ex(0, 32'd4, 1'b0);
        ex(0, 32'd5, 1'b0);
        base = n_acks;
        wait_acks(base + 1, 50);
        repeat (3) @(posedge clock);
        #2;
        bus.I_Nack = 1'b0;
        wait_idle(100);
`ifdef SHIFT_ISSUE_ARB_STATS_EN
        chk("stats_grant0", gcnt0, 5);
        chk("stats_grant1", gcnt1, 3);
        chk("stats_stall", scnt, 2);
`endif
        chk("final_err_clear", bus.O_Err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
